// File: rtl/uart_tx_os.sv
// Oversampled UART transmitter: start, LSB-first data, optional parity, stop; each bit lasts Prescale clocks.
// Optional feature: define UART_TX_TWO_STOP_EN for two stop bits (default build sends one).
module uart_tx_os #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 5
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      Data_valid,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    output logic                      TX_OUT,
    output logic                      Busy,
    output logic [2:0]                state_dbg
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    // Handshake: a word is taken on any CLK edge where the FSM is IDLE and
    // Data_valid=1; Busy acts as the inverse of ready and is high for the whole
    // frame, during which Data_valid is ignored (nothing is queued).

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] clk_cnt_q, clk_cnt_d;
    logic [IDX_W-1:0]          bit_idx_q, bit_idx_d;
    logic [DATA_WIDTH-1:0]     data_q;
    logic [PRESCALE_WIDTH-1:0] presc_q;
    logic                      par_en_q;
    logic                      par_typ_q;
    logic                      load;
    logic                      tx_d;
    logic                      busy_d;
    logic                      bit_end;
    logic                      par_bit;
    logic [PRESCALE_WIDTH-1:0] presc_last;

`ifdef UART_TX_TWO_STOP_EN
    logic stop_cnt_q, stop_cnt_d;
`endif

    // Latched Prescale of 0 wraps to all-ones, i.e. a period of 2**PRESCALE_WIDTH.
    assign presc_last = presc_q - PRESCALE_WIDTH'(1);
    assign bit_end    = (clk_cnt_q == presc_last);
    assign par_bit    = par_typ_q ? ~^data_q : ^data_q;
    assign state_dbg  = state_q;

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        load      = 1'b0;
`ifdef UART_TX_TWO_STOP_EN
        stop_cnt_d = stop_cnt_q;
`endif

        if (state_q == S_IDLE) begin
            clk_cnt_d = '0;
        end else if (bit_end) begin
            clk_cnt_d = '0;
        end else begin
            clk_cnt_d = clk_cnt_q + PRESCALE_WIDTH'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (Data_valid) begin
                    state_d = S_START;
                    load    = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    bit_idx_d = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == IDX_W'(DATA_WIDTH - 1)) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
`ifdef UART_TX_TWO_STOP_EN
                        stop_cnt_d = 1'b0;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
`ifdef UART_TX_TWO_STOP_EN
                    stop_cnt_d = 1'b0;
`endif
                end
            end
            S_STOP: begin
                if (bit_end) begin
`ifdef UART_TX_TWO_STOP_EN
                    if (!stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
`else
                    state_d = S_IDLE;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Line level is decoded from the next state so TX_OUT comes straight from a flop.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != S_IDLE);
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = data_q[bit_idx_d];
            S_PARITY: tx_d = par_bit;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            data_q    <= '0;
            presc_q   <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            TX_OUT    <= 1'b1;
            Busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            TX_OUT    <= tx_d;
            Busy      <= busy_d;
            if (load) begin
                data_q    <= P_DATA;
                presc_q   <= Prescale;
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
            end
        end
    end

`ifdef UART_TX_TWO_STOP_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stop_cnt_q <= 1'b0;
        end else begin
            stop_cnt_q <= stop_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_os.sv
// Directed bench for uart_tx_os: per-clock line/Busy checks of whole frames,
// mid-frame request rejection, async reset abort and Prescale corner values.
module tb_uart_tx_os;

`ifdef UART_TX_TWO_STOP_EN
    localparam int STOP_BITS = 2;
`else
    localparam int STOP_BITS = 1;
`endif

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_valid;
    logic [4:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       TX_OUT;
    logic       Busy;
    logic [2:0] state_dbg;

    int checks   = 0;
    int failures = 0;

    uart_tx_os #(.DATA_WIDTH(8), .PRESCALE_WIDTH(5)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_valid (Data_valid),
        .Prescale   (Prescale),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle_check(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_idle_tx"}, TX_OUT, 1);
            chk({tag, "_idle_busy"}, Busy, 0);
            step();
        end
    endtask

    // Sends one frame and checks every clock of it. Caller is #1 after an edge
    // in IDLE. Inputs are scrambled right after acceptance; inject>=0 pulses a
    // 0x3C request at that Busy cycle, which must be ignored.
    task automatic send_frame(input logic [7:0] d, input logic [4:0] pre,
                              input logic pen, input logic ptyp, input logic epar,
                              input int inject, input string tag);
        int   p;
        int   nbits;
        int   k;
        logic ebit;
        p     = (pre == 5'd0) ? 32 : int'(pre);
        nbits = 1 + 8 + int'(pen) + STOP_BITS;
        chk({tag, "_pre_tx"}, TX_OUT, 1);
        chk({tag, "_pre_busy"}, Busy, 0);
        P_DATA = d; Prescale = pre; PAR_EN = pen; PAR_TYP = ptyp; Data_valid = 1'b1;
        step();
        Data_valid = 1'b0;
        P_DATA = ~d; Prescale = pre + 5'd3; PAR_EN = ~pen; PAR_TYP = ~ptyp;
        for (int b = 0; b < nbits; b++) begin
            if (b == 0)                 ebit = 1'b0;
            else if (b <= 8)            ebit = d[b-1];
            else if (pen && b == 9)     ebit = epar;
            else                        ebit = 1'b1;
            for (int c = 0; c < p; c++) begin
                k = b * p + c;
                chk($sformatf("%s_bit%0d_clk%0d_tx", tag, b, c), TX_OUT, ebit);
                chk($sformatf("%s_bit%0d_clk%0d_busy", tag, b, c), Busy, 1);
                if (k == inject) begin
                    P_DATA = 8'h3C; Data_valid = 1'b1;
                end else begin
                    Data_valid = 1'b0;
                end
                step();
            end
        end
        Data_valid = 1'b0;
    endtask

    initial begin
        RST = 1'b1; P_DATA = 8'h00; Data_valid = 1'b0; Prescale = 5'd8;
        PAR_EN = 1'b0; PAR_TYP = 1'b0;
        #1;
        chk("reset_tx", TX_OUT, 1);
        chk("reset_busy", Busy, 0);
        chk("reset_state", state_dbg, 0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        step();
        idle_check(3, "post_reset");

        // 0xA5 even parity -> parity bit 0
        send_frame(8'hA5, 5'd8, 1'b1, 1'b0, 1'b0, -1, "a5_even");
        // back-to-back: one idle clock between frames, odd parity -> 1
        send_frame(8'hA5, 5'd8, 1'b1, 1'b1, 1'b1, -1, "a5_odd");
        // no parity: 10 bits
        send_frame(8'hA5, 5'd8, 1'b0, 1'b0, 1'b0, -1, "a5_nopar");
        idle_check(2, "gap1");

        // request at busy cycle 20 must be dropped
        send_frame(8'hFF, 5'd8, 1'b1, 1'b0, 1'b0, 20, "ff_inject");
        idle_check(12, "no_queue");
        chk("no_queue_state", state_dbg, 0);

        // async reset at busy cycle 30
        P_DATA = 8'h77; Prescale = 5'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_valid = 1'b1;
        step();
        Data_valid = 1'b0;
        repeat (30) step();
        chk("pre_abort_busy", Busy, 1);
        #2;
        RST = 1'b1;
        #1;
        chk("abort_tx", TX_OUT, 1);
        chk("abort_busy", Busy, 0);
        chk("abort_state", state_dbg, 0);
        @(negedge CLK);
        RST = 1'b0;
        step();
        idle_check(2, "after_abort");
        send_frame(8'h5A, 5'd8, 1'b1, 1'b1, 1'b1, -1, "5a_odd");
        idle_check(1, "gap2");

        // Prescale corners
        send_frame(8'hC3, 5'd0, 1'b1, 1'b0, 1'b0, -1, "c3_p32");
        idle_check(1, "gap3");
        send_frame(8'h81, 5'd1, 1'b0, 1'b0, 1'b0, -1, "81_p1");
        send_frame(8'h01, 5'd1, 1'b1, 1'b0, 1'b1, -1, "01_p1_even");
        send_frame(8'h3C, 5'd2, 1'b1, 1'b1, 1'b1, -1, "3c_p2_odd");
        idle_check(4, "final");
        chk("final_state", state_dbg, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
